// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: round-robin write/read access to a bit storage with clear, acknowledge wait and timeout.
module memory_access_arbiter #(
  parameter int ROWINDEXBITS  = 4,
  parameter int COLINDEXBITS  = 4,
  parameter int TIMEOUTCYCLES = 64,
  parameter int ADDRBITS      = ROWINDEXBITS + COLINDEXBITS
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    startClear,
  input  logic                    wrValid,
  input  logic [ADDRBITS-1:0]     wrAddress,
  output logic                    wrReady,
  input  logic                    rdValid,
  input  logic [ROWINDEXBITS-1:0] rdWordIndex,
  input  logic [COLINDEXBITS-1:0] rdLetterIndex,
  output logic                    rdReady,
  output logic                    rdDataValid,
  output logic                    rdData,
  output logic [ADDRBITS-1:0]     memAddress,
  output logic                    memNewAddress,
  output logic                    memClear,
  output logic                    memRead,
  input  logic                    memStorageReady,
  input  logic                    memReadReady,
  input  logic                    memStoredValue,
  output logic                    busy,
  output logic                    timeoutError
);
  typedef enum logic [2:0] {CLEAR, CLRWAIT, IDLE, WRITE, READ} state_t;
  localparam int CW = $clog2(TIMEOUTCYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic pref_wr, waiting, ack, expired, idle, grant_wr;
  always_comb begin
    waiting  = state == CLRWAIT || state == WRITE || state == READ;
    ack      = (state == READ) ? memReadReady : memStorageReady;
    expired  = waiting && !ack && cnt == CW'(TIMEOUTCYCLES - 1);
    idle     = state == IDLE && !startClear;
    grant_wr = wrValid && (!rdValid || pref_wr);
    wrReady  = idle && grant_wr;
    rdReady  = idle && rdValid && !grant_wr;
    state_n  = state == CLEAR ? CLRWAIT :
               state == IDLE  ? (startClear ? CLEAR : wrReady ? WRITE : rdReady ? READ : IDLE) :
               (ack || expired) ? IDLE : state;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= CLEAR;
      cnt           <= '0;
      pref_wr       <= 1'b1;
      memAddress    <= '0;
      memNewAddress <= 1'b0;
      memClear      <= 1'b0;
      memRead       <= 1'b0;
      busy          <= 1'b0;
      rdDataValid   <= 1'b0;
      rdData        <= 1'b0;
      timeoutError  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= (waiting && state_n == state) ? cnt + 1'b1 : '0;
      memNewAddress <= wrReady;
      memClear      <= state == CLEAR;
      memRead       <= rdReady || (state == READ && state_n == READ);
      busy          <= state_n != IDLE;
      rdDataValid   <= state == READ && ack;
      timeoutError  <= (state == IDLE && startClear) ? 1'b0 : timeoutError | expired;
      if (state == READ && ack) rdData <= memStoredValue;
      if (wrReady) memAddress <= wrAddress;
      else if (rdReady) memAddress <= {rdWordIndex, rdLetterIndex};
      if (wrReady || rdReady) pref_wr <= rdReady;
    end
  end
endmodule

// File: tb/tb_memory_access_arbiter.sv
// tb_memory_access_arbiter: self-checking bench for memory_access_arbiter.
module tb_memory_access_arbiter;
  localparam int RB = 4, CB = 4, AB = RB + CB, T = 8;
  logic clock = 0, resetN = 0;
  logic startClear, wrValid, rdValid, memStorageReady, memReadReady, memStoredValue;
  logic [AB-1:0] wrAddress;
  logic [RB-1:0] rdWordIndex;
  logic [CB-1:0] rdLetterIndex;
  logic wrReady, rdReady, rdDataValid, rdData, memNewAddress, memClear, memRead, busy, timeoutError;
  logic [AB-1:0] memAddress;
  int checks = 0, errors = 0;
  logic pref_wr_m, te_m, rd_m;

  memory_access_arbiter #(.ROWINDEXBITS(RB), .COLINDEXBITS(CB), .TIMEOUTCYCLES(T)) dut (
    .clock(clock), .resetN(resetN), .startClear(startClear),
    .wrValid(wrValid), .wrAddress(wrAddress), .wrReady(wrReady),
    .rdValid(rdValid), .rdWordIndex(rdWordIndex), .rdLetterIndex(rdLetterIndex), .rdReady(rdReady),
    .rdDataValid(rdDataValid), .rdData(rdData),
    .memAddress(memAddress), .memNewAddress(memNewAddress), .memClear(memClear), .memRead(memRead),
    .memStorageReady(memStorageReady), .memReadReady(memReadReady), .memStoredValue(memStoredValue),
    .busy(busy), .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    startClear = 0; wrValid = 0; rdValid = 0; memStorageReady = 0; memReadReady = 0;
    memStoredValue = 0; wrAddress = '0; rdWordIndex = '0; rdLetterIndex = '0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({wrReady, rdReady, rdDataValid, rdData, memAddress, memNewAddress, memClear, memRead, busy, timeoutError});
  endfunction

  task automatic do_reset;
    idle_inputs();
    resetN = 0;
    step(); step();
    chk("reset_outputs", all_outs(), 0);
    resetN = 1;
    step();
    chk("clr_pulse", memClear, 1);
    chk("clr_busy", busy, 1);
    step();
    chk("clr_drop", memClear, 0);
    memStorageReady = 1;
    step();
    memStorageReady = 0;
    chk("clr_done_busy", busy, 0);
    pref_wr_m = 1; te_m = 0; rd_m = 0;
  endtask

  task automatic start_clear;
    startClear = 1; wrValid = 1; rdValid = 1;
    #1;
    chk("clr_ready_low", {wrReady, rdReady}, 0);
    step();
    startClear = 0; wrValid = 0; rdValid = 0;
    te_m = 0;
    chk("clr_te_cleared", timeoutError, 0);
    chk("clr_accept_busy", busy, 1);
    step();
    chk("sclr_pulse", memClear, 1);
    memStorageReady = 1;
    step();
    memStorageReady = 0;
    chk("sclr_drop", memClear, 0);
    chk("sclr_done_busy", busy, 0);
  endtask

  task automatic txn(input logic wv, input logic rv, input logic [AB-1:0] wa, input logic [RB-1:0] ri,
                     input logic [CB-1:0] ci, input int d, input logic val, output logic got_wr);
    logic g_wr, g_rd, done, timed_out;
    logic [AB-1:0] exp_addr;
    int cycles;
    wrValid = wv; rdValid = rv; wrAddress = wa; rdWordIndex = ri; rdLetterIndex = ci;
    #1;
    g_wr = wv && (!rv || pref_wr_m);
    g_rd = rv && !g_wr;
    got_wr = wrReady;
    chk("wr_ready", wrReady, g_wr);
    chk("rd_ready", rdReady, g_rd);
    exp_addr = g_wr ? wa : {ri, ci};
    pref_wr_m = g_rd;
    step();
    chk("acc_addr", memAddress, exp_addr);
    chk("acc_newaddr", memNewAddress, g_wr);
    chk("acc_memread", memRead, g_rd);
    chk("acc_busy", busy, 1);
    cycles = 0; done = 0;
    while (!done) begin
      memStoredValue = val;
      memStorageReady = g_wr && cycles == d;
      memReadReady = g_rd && cycles == d;
      step();
      cycles++;
      done = (cycles == d + 1) || (cycles >= T);
      if (!done) begin
        chk("wait_ready", {wrReady, rdReady}, 0);
        chk("wait_busy", busy, 1);
        chk("wait_rdvalid", rdDataValid, 0);
        chk("wait_memread", memRead, g_rd);
        chk("wait_newaddr", memNewAddress, 0);
      end
    end
    wrValid = 0; rdValid = 0; memStorageReady = 0; memReadReady = 0;
    timed_out = d >= T;
    if (g_rd && !timed_out) rd_m = val;
    te_m = te_m | timed_out;
    chk("done_busy", busy, 0);
    chk("done_rdvalid", rdDataValid, g_rd && !timed_out);
    chk("done_rddata", rdData, rd_m);
    chk("done_memread", memRead, 0);
    chk("done_timeout", timeoutError, te_m);
    chk("done_addr_hold", memAddress, exp_addr);
    step();
    chk("strobe_once", rdDataValid, 0);
  endtask

  typedef struct { logic wv, rv, sc, sr, rr, ew, er; } vec_t;
  vec_t tbl[7];

  initial begin
    logic g;
    logic [3:0] hist;
    tbl[0] = '{0, 0, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 1, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wrValid = tbl[i].wv; rdValid = tbl[i].rv; startClear = tbl[i].sc;
      memStorageReady = tbl[i].sr; memReadReady = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d_wr", i), wrReady, tbl[i].ew);
      chk($sformatf("vec%0d_rd", i), rdReady, tbl[i].er);
    end
    idle_inputs();
    memStorageReady = 1; memReadReady = 1;
    step();
    chk("idle_ack_ignored", {busy, rdDataValid}, 0);
    idle_inputs();
    txn(1, 0, 8'h05, 0, 0, 2, 0, g);
    txn(0, 1, 8'h00, 4'd2, 4'd1, 0, 1, g);
    hist = '0;
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 8'(8'h30 + i), 4'(i), 4'(i + 3), 1, 1'(i), g);
      hist = {hist[2:0], g};
    end
    chk("grant_order", hist, 4'b1010);
    txn(0, 1, 8'h00, 4'd7, 4'd9, T - 1, 1, g);
    txn(1, 0, 8'hA5, 0, 0, T - 1, 0, g);
    txn(0, 1, 8'h00, 4'd3, 4'd3, T, 0, g);
    chk("timeout_sticky", timeoutError, 1);
    start_clear();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1], 8'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, T + 1), 1'($urandom), g);
      if (te_m) start_clear();
    end
    rdValid = 1; rdWordIndex = 4'd5; rdLetterIndex = 4'd6;
    step();
    rdValid = 0;
    step();
    chk("pre_abort_memread", memRead, 1);
    resetN = 0;
    #1;
    chk("abort_outputs", all_outs(), 0);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_access_arbiter.md
MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

Interface
REQ-001 Parameters SHALL be: ROWINDEXBITS, default from MyParameters.vh, word-index width; COLINDEXBITS, default from MyParameters.vh, letter-index width; TIMEOUTCYCLES, default 64, maximum wait for a storage acknowledge; ADDRBITS equals ROWINDEXBITS+COLINDEXBITS.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 resetN  in  1  reset, asynchronous, active-low.
REQ-004 startClear  in  1  one-cycle request to clear the storage.
REQ-005 wrValid  in  1  write requester has an address; wrAddress  in  ADDRBITS  write address; wrReady  out  1  write accepted this cycle.
REQ-006 rdValid  in  1  inquiry pending; rdWordIndex  in  ROWINDEXBITS; rdLetterIndex  in  COLINDEXBITS; rdReady  out  1  inquiry accepted this cycle.
REQ-007 rdDataValid  out  1  one-cycle result strobe; rdData  out  1  stored bit returned.
REQ-008 memAddress  out  ADDRBITS; memNewAddress  out  1; memClear  out  1; memRead  out  1; these drive the storage block.
REQ-009 memStorageReady  in  1; memReadReady  in  1; memStoredValue  in  1; these come from the storage block.
REQ-010 busy  out  1  high in any state other than IDLE; timeoutError  out  1  sticky fault flag.

Function
REQ-011 FSM states SHALL be: CLEAR, CLRWAIT, IDLE, WRITE, READ.
REQ-012 CLEAR SHALL assert memClear for exactly one cycle and then go to CLRWAIT.
REQ-013 CLRWAIT SHALL go to IDLE in the cycle after memStorageReady is sampled high.
REQ-014 IDLE priority SHALL be: startClear first, then requesters.
- Both requesters valid: round-robin; the requester not granted last wins.
- Round-robin pointer after reset: write.
REQ-015 wrReady and rdReady SHALL be combinational and high only in IDLE, for the granted requester, when startClear is low; at most one is high per cycle.
REQ-016 Write accept (wrValid and wrReady) SHALL:
- register wrAddress into memAddress;
- enter WRITE next cycle with memNewAddress high for exactly that first cycle;
- stay in WRITE until memStorageReady is sampled high, then go to IDLE.
REQ-017 Read accept SHALL:
- register memAddress as {rdWordIndex, rdLetterIndex}, word index in the MSBs;
- enter READ with memRead held high until memReadReady is sampled high;
- on that cycle, capture memStoredValue into rdData, pulse rdDataValid for one cycle, drop memRead and go to IDLE.
REQ-018 Result latency SHALL be as follows: rdDataValid rises one cycle after the memReadReady sample; minimum 2 cycles from accept.
REQ-019 memAddress SHALL hold its value outside accept cycles; rdData SHALL hold until the next read completes.
REQ-020 A wait counter SHALL:
- clear on entry to WRITE, READ or CLRWAIT and increment each waiting cycle;
- on reaching TIMEOUTCYCLES without acknowledge, set timeoutError, drop memRead, return to IDLE, with no rdDataValid.
REQ-021 timeoutError SHALL stay set until reset or until a startClear is accepted.
REQ-022 An acknowledge arriving in the same cycle the counter reaches TIMEOUTCYCLES SHALL count as success; timeoutError is not set.
REQ-023 startClear outside IDLE SHALL be ignored; requests outside IDLE SHALL see ready low and be held by the requester.
REQ-024 Unexpected memStorageReady or memReadReady in IDLE SHALL be ignored.

Reset
REQ-025 While resetN is low, all outputs SHALL be 0: memAddress 0, pointer to write, counter 0, state CLEAR.
REQ-026 The first rising edge after resetN releases SHALL issue the memClear pulse, so the storage is cleared after every reset.
REQ-027 resetN asserted mid-transaction SHALL abort immediately with no rdDataValid; the requester's transaction is lost.

Verification
REQ-028 Reset release with memStorageReady high 3 cycles later -> memClear high 1 cycle, busy falls 1 cycle after that sample, state IDLE.
REQ-029 Write wrAddress=0x05, storage ack after 2 cycles -> memAddress=0x05, memNewAddress 1-cycle pulse, wrReady low until IDLE is re-entered.
REQ-030 Read rdWordIndex=2, rdLetterIndex=1, memStoredValue=1 with memReadReady -> memAddress={2,1}, memRead held, rdDataValid 1 cycle, rdData=1.
REQ-031 wrValid and rdValid held high for 4 transactions -> grant order write, read, write, read.
REQ-032 Read with no memReadReady -> after TIMEOUTCYCLES timeoutError=1, no rdDataValid, state IDLE; a later accepted startClear clears timeoutError.
REQ-033 resetN pulsed low during READ -> outputs 0 at once, then a fresh CLEAR sequence.
